// File: rtl/screen_frame_loader.sv
// Memory-mapped frame loader: the CPU posts RGB888 pixels into a FIFO, and the loader quantises
// them and streams one per clock to the HUB75 screen driver until a full frame has been sent.
module screen_frame_loader #(
    parameter int NUM_PIXELS = 4096,
    parameter int FIFO_DEPTH = 16,
    parameter int BIT_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        we,
    input  logic        rd,
    input  logic [1:0]  addr,
    input  logic [31:0] d_in,
    output logic [31:0] d_out,
    output logic        init,
    output logic        wr_data,
    output logic [31:0] mat_in,
    output logic        frame_irq
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int FCW = AW + 1;
    localparam int CW  = $clog2(NUM_PIXELS + 1);

    typedef enum logic [1:0] {IDLE, INIT_HI, INIT_LO, STREAM} state_t;

    state_t             state;
    logic               init_cnt;
    logic [23:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]      rd_ptr, wr_ptr;
    logic [FCW-1:0]     fifo_count;
    logic [CW-1:0]      count;
    logic               busy, done, overflow;

    logic wr_ctrl, wr_pix, start, abort, full, empty, frame_full, frame_end;
    logic pop, push, flush;
    logic [23:0]          head;
    logic [3*BIT_DEPTH-1:0] quant;

    assign wr_ctrl    = cs & we & (addr == 2'd0);
    assign wr_pix     = cs & we & (addr == 2'd1);
    assign abort      = wr_ctrl & d_in[1];
    assign start      = wr_ctrl & d_in[0] & ~d_in[1] & (state == IDLE);
    assign full       = (fifo_count == FCW'(FIFO_DEPTH));
    assign empty      = (fifo_count == '0);
    assign frame_full = (count == CW'(NUM_PIXELS));
    assign frame_end  = (state == STREAM) & frame_full & ~abort;
    assign pop        = (state == STREAM) & ~empty & ~frame_full & ~abort;
    // A pop in the same cycle frees the slot, so a write to a full FIFO is still accepted then.
    assign push       = wr_pix & busy & (~full | pop);
    assign flush      = abort | start | frame_end;

    assign head  = mem[rd_ptr];
    assign quant = {head[23 -: BIT_DEPTH], head[15 -: BIT_DEPTH], head[7 -: BIT_DEPTH]};

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= d_in[23:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (flush) begin
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                fifo_count <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   fifo_count <= fifo_count + FCW'(1);
                    2'b01:   fifo_count <= fifo_count - FCW'(1);
                    default: fifo_count <= fifo_count;
                endcase
            end
            if (start)
                overflow <= 1'b0;
            else if (wr_pix && busy && full && !pop && !flush)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            init_cnt  <= 1'b0;
            init      <= 1'b0;
            wr_data   <= 1'b0;
            mat_in    <= '0;
            frame_irq <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
        end else begin
            wr_data   <= 1'b0;
            frame_irq <= 1'b0;
            if (abort) begin
                state <= IDLE;
                init  <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        state    <= INIT_HI;
                        init     <= 1'b1;
                        init_cnt <= 1'b0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        count    <= '0;
                    end
                    INIT_HI: begin
                        init_cnt <= 1'b1;
                        if (init_cnt) begin
                            init  <= 1'b0;
                            state <= INIT_LO;
                        end
                    end
                    INIT_LO: state <= STREAM;
                    STREAM: begin
                        // Frame completes the cycle after the last pixel left; leftovers are dropped by flush.
                        if (frame_full) begin
                            frame_irq <= 1'b1;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end else if (pop) begin
                            wr_data <= 1'b1;
                            mat_in  <= 32'(quant);
                            count   <= count + CW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_out <= '0;
        end else if (cs && rd) begin
            case (addr)
                2'd2:    d_out <= {16'b0, 8'(fifo_count), 5'b0, overflow, done, busy};
                2'd3:    d_out <= 32'(count);
                default: d_out <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_screen_frame_loader.sv
// Directed bench for screen_frame_loader: quantisation table, full frame, overflow, abort, reset.
module tb_screen_frame_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs = 1'b0, we = 1'b0, rd = 1'b0;
    logic [1:0]  addr = '0;
    logic [31:0] d_in = '0;
    logic [31:0] d_out;
    logic        init, wr_data, frame_irq;
    logic [31:0] mat_in;

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    int irqs   = 0;
    int px_bad = 0;
    bit sb_on  = 0;
    logic [31:0] exp_q [$];

    typedef struct {
        logic [31:0] pix;
        logic [31:0] exp_mat;
    } vec_t;
    vec_t tbl [6];

    screen_frame_loader dut (
        .clk(clk), .reset(reset), .cs(cs), .we(we), .rd(rd), .addr(addr),
        .d_in(d_in), .d_out(d_out), .init(init), .wr_data(wr_data),
        .mat_in(mat_in), .frame_irq(frame_irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_data) begin
            pulses++;
            if (sb_on) begin
                if (exp_q.size() == 0) px_bad++;
                else if (mat_in !== exp_q.pop_front()) px_bad++;
            end
        end
        if (frame_irq) irqs++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        cs = 1'b1; we = 1'b1; addr = a; d_in = d;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        d = d_out;
    endtask

    function automatic logic [31:0] q4(input logic [31:0] p);
        return {20'b0, p[23:20], p[15:12], p[7:4]};
    endfunction

    task automatic start_frame();
        bus_wr(2'd0, 32'h1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        tbl[0] = '{32'h00F08010, 32'h00000F81};
        tbl[1] = '{32'h00FFFFFF, 32'h00000FFF};
        tbl[2] = '{32'h00000000, 32'h00000000};
        tbl[3] = '{32'h0012AB7F, 32'h000001A7};
        tbl[4] = '{32'hFF0F0F0F, 32'h00000000};
        tbl[5] = '{32'h00801FE0, 32'h0000081E};

        // reset state
        #1;
        chk("rst_init", 32'(init), 32'h0);
        chk("rst_wr_data", 32'(wr_data), 32'h0);
        chk("rst_mat_in", mat_in, 32'h0);
        chk("rst_d_out", d_out, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        bus_rd(2'd2, r);
        chk("rst_status", r, 32'h0);

        // START: init high two cycles then low, busy set
        bus_wr(2'd0, 32'h1);
        chk("init_hi_1", 32'(init), 32'h1);
        @(negedge clk);
        chk("init_hi_2", 32'(init), 32'h1);
        @(negedge clk);
        chk("init_lo", 32'(init), 32'h0);
        bus_rd(2'd2, r);
        chk("busy_status", r, 32'h1);

        // quantisation table, one pixel at a time with empty FIFO
        for (int i = 0; i < 6; i++) begin
            bus_wr(2'd1, tbl[i].pix);
            chk($sformatf("lat_wr_lo_%0d", i), 32'(wr_data), 32'h0);
            @(negedge clk);
            chk($sformatf("vec_wr_%0d", i), 32'(wr_data), 32'h1);
            chk($sformatf("vec_mat_%0d", i), mat_in, tbl[i].exp_mat);
        end
        @(negedge clk);
        bus_rd(2'd3, r);
        chk("vec_count", r, 32'd6);

        // ABORT and START together: abort wins, done stays clear
        bus_wr(2'd0, 32'h3);
        bus_rd(2'd2, r);
        chk("abort_wins", r, 32'h0);

        // full frame back-to-back
        start_frame();
        pulses = 0; irqs = 0; px_bad = 0; sb_on = 1;
        for (int i = 0; i < 4096; i++) begin
            logic [31:0] p;
            p = 32'(i) * 32'h00010307;
            exp_q.push_back(q4(p));
            bus_wr(2'd1, p);
        end
        repeat (5) @(negedge clk);
        sb_on = 0;
        chk("frame_pulses", 32'(pulses), 32'd4096);
        chk("frame_irqs", 32'(irqs), 32'd1);
        chk("frame_px", 32'(px_bad), 32'd0);
        chk("frame_sb_left", 32'(exp_q.size()), 32'd0);
        bus_rd(2'd3, r);
        chk("frame_count", r, 32'd4096);
        bus_rd(2'd2, r);
        chk("frame_status", r, 32'h2);
        // pixel while idle is ignored; abort while idle leaves done alone
        bus_wr(2'd1, 32'h00ABCDEF);
        @(negedge clk);
        chk("idle_pix_nopulse", 32'(pulses), 32'd4096);
        bus_wr(2'd0, 32'h2);
        bus_rd(2'd2, r);
        chk("idle_abort_done", r, 32'h2);

        // overflow with stalled stream
        start_frame();
        pulses = 0;
        force dut.pop = 1'b0;
        for (int i = 0; i < 16; i++) bus_wr(2'd1, 32'(i));
        bus_rd(2'd2, r);
        chk("fifo_full_status", r, 32'h1001);
        bus_wr(2'd1, 32'h16);
        bus_rd(2'd2, r);
        chk("overflow_status", r, 32'h1005);
        release dut.pop;
        bus_wr(2'd1, 32'h17);
        repeat (20) @(negedge clk);
        chk("ovf_pulses", 32'(pulses), 32'd17);
        bus_rd(2'd3, r);
        chk("ovf_count", r, 32'd17);
        bus_rd(2'd2, r);
        chk("ovf_sticky", r, 32'h5);
        bus_wr(2'd0, 32'h2);
        bus_wr(2'd0, 32'h1);
        bus_rd(2'd2, r);
        chk("ovf_cleared", r, 32'h1);
        bus_wr(2'd0, 32'h2);

        // abort after 100 pixels with two queued
        start_frame();
        pulses = 0;
        for (int i = 0; i < 100; i++) bus_wr(2'd1, 32'h00808080);
        @(negedge clk);
        bus_wr(2'd0, 32'h1);
        chk("start_busy_ignored", 32'(init), 32'h0);
        force dut.pop = 1'b0;
        bus_wr(2'd1, 32'h1);
        bus_wr(2'd1, 32'h2);
        bus_wr(2'd0, 32'h2);
        release dut.pop;
        chk("abort_wr_data", 32'(wr_data), 32'h0);
        repeat (3) @(negedge clk);
        chk("abort_pulses", 32'(pulses), 32'd100);
        bus_rd(2'd2, r);
        chk("abort_status", r, 32'h0);
        bus_rd(2'd3, r);
        chk("abort_count", r, 32'd100);

        // asynchronous reset mid-stream
        start_frame();
        bus_wr(2'd1, 32'h00FFFFFF);
        @(posedge clk);
        #1;
        chk("pre_rst_wr_data", 32'(wr_data), 32'h1);
        reset = 1'b1;
        #1;
        chk("arst_wr_data", 32'(wr_data), 32'h0);
        chk("arst_mat_in", mat_in, 32'h0);
        chk("arst_init", 32'(init), 32'h0);
        chk("arst_irq", 32'(frame_irq), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        bus_rd(2'd2, r);
        chk("arst_status", r, 32'h0);
        bus_rd(2'd3, r);
        chk("arst_count", r, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
